// File: rtl/dcache_assoc_if.sv
// Datapath-side and memory-side signals of the 2-way data cache.
interface dcache_assoc_if;
  logic        dmemREN;
  logic        dmemWEN;
  logic [31:0] dmemaddr;
  logic [31:0] dmemstore;
  logic        halt;
  logic        dhit;
  logic [31:0] dmemload;
  logic        flushed;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic [31:0] dload;
  logic        dwait;

  // The cache serves the datapath and issues transfers to memory.
  modport slave (
    input  dmemREN, dmemWEN, dmemaddr, dmemstore, halt, dload, dwait,
    output dhit, dmemload, flushed, dREN, dWEN, daddr, dstore
  );

  // Environment side: datapath requests plus the memory responder.
  modport master (
    output dmemREN, dmemWEN, dmemaddr, dmemstore, halt, dload, dwait,
    input  dhit, dmemload, flushed, dREN, dWEN, daddr, dstore
  );
endinterface

// File: rtl/dcache_assoc.sv
// 2-way set-associative, write-back, write-allocate data cache with LRU
// replacement and a halt-triggered flush that finally stores the hit count.
module dcache_assoc #(
  parameter int unsigned SETS    = 8,
  parameter int unsigned WORDS   = 2,
  parameter logic [31:0] HITADDR = 32'h00003100
) (
  input logic           CLK,
  input logic           RST,
  dcache_assoc_if.slave bus
);
  localparam int unsigned OFFB = $clog2(WORDS);
  localparam int unsigned IDXB = $clog2(SETS);
  localparam int unsigned TAGB = 30 - OFFB - IDXB;
  localparam int unsigned WCB  = (OFFB > 0) ? OFFB : 1;

  typedef enum logic [2:0] {IDLE, WB, FILL, FLUSH, HITWR, DONE} stateT;

  stateT            state, nextState;
  logic [TAGB-1:0]  tags [SETS][2];
  logic [31:0]      data [2][SETS][WORDS];
  logic [1:0]       valid [SETS];
  logic [1:0]       dirty [SETS];
  logic [SETS-1:0]  lru;
  logic [TAGB-1:0]  missTag;
  logic [IDXB-1:0]  missIdx;
  logic             victim;
  logic [WCB-1:0]   wordCnt;
  logic [IDXB-1:0]  flushSet;
  logic             flushWay;
  logic [31:0]      hitCount;

  logic [TAGB-1:0]  reqTag;
  logic [IDXB-1:0]  reqIdx;
  logic [WCB-1:0]   reqWord;
  logic             req, hit0, hit1, anyHit, hitWay, newVictim;
  logic             lastWord, lastLine;
  logic             hitUpd, startMiss, wordInc, wordClr, fillWe, install, lineAdv, lineClean;
  logic             unusedBits;

  function automatic logic [31:0] mkAddr(input logic [TAGB-1:0] t, input logic [IDXB-1:0] i,
                                         input logic [WCB-1:0] w);
    return (32'(t) << (2 + OFFB + IDXB)) | (32'(i) << (2 + OFFB)) | (32'(w) << 2);
  endfunction

  assign reqTag     = bus.dmemaddr[31 -: TAGB];
  assign reqIdx     = bus.dmemaddr[2 + OFFB +: IDXB];
  // With one word per block the offset field is empty, so the word is always 0.
  assign reqWord    = (OFFB == 0) ? '0 : bus.dmemaddr[2 +: WCB];
  assign req        = bus.dmemREN | bus.dmemWEN;
  assign hit0       = valid[reqIdx][0] && (tags[reqIdx][0] == reqTag);
  assign hit1       = valid[reqIdx][1] && (tags[reqIdx][1] == reqTag);
  assign anyHit     = hit0 | hit1;
  assign hitWay     = ~hit0;
  assign newVictim  = !valid[reqIdx][0] ? 1'b0 : (!valid[reqIdx][1] ? 1'b1 : lru[reqIdx]);
  assign lastWord   = (wordCnt == WCB'(WORDS - 1));
  assign lastLine   = (flushSet == IDXB'(SETS - 1)) && flushWay;
  assign unusedBits = ^bus.dmemaddr[1:0];

  // Next-state, memory strobes and datapath outputs.
  always_comb begin
    nextState    = state;
    hitUpd       = 1'b0;
    startMiss    = 1'b0;
    wordInc      = 1'b0;
    wordClr      = 1'b0;
    fillWe       = 1'b0;
    install      = 1'b0;
    lineAdv      = 1'b0;
    lineClean    = 1'b0;
    bus.dhit     = 1'b0;
    bus.dmemload = '0;
    bus.flushed  = 1'b0;
    bus.dREN     = 1'b0;
    bus.dWEN     = 1'b0;
    bus.daddr    = '0;
    bus.dstore   = '0;
    unique case (state)
      IDLE: begin
        if (bus.halt) begin
          nextState = FLUSH;
        end else if (req) begin
          if (anyHit) begin
            bus.dhit     = 1'b1;
            bus.dmemload = data[hitWay][reqIdx][reqWord];
            hitUpd       = 1'b1;
          end else begin
            startMiss = 1'b1;
            nextState = (valid[reqIdx][newVictim] && dirty[reqIdx][newVictim]) ? WB : FILL;
          end
        end
      end
      WB: begin
        bus.dWEN   = 1'b1;
        bus.daddr  = mkAddr(tags[missIdx][victim], missIdx, wordCnt);
        bus.dstore = data[victim][missIdx][wordCnt];
        if (!bus.dwait) begin
          if (lastWord) begin
            wordClr   = 1'b1;
            nextState = FILL;
          end else begin
            wordInc = 1'b1;
          end
        end
      end
      FILL: begin
        bus.dREN  = 1'b1;
        bus.daddr = mkAddr(missTag, missIdx, wordCnt);
        if (!bus.dwait) begin
          fillWe = 1'b1;
          if (lastWord) begin
            install   = 1'b1;
            wordClr   = 1'b1;
            nextState = IDLE;
          end else begin
            wordInc = 1'b1;
          end
        end
      end
      FLUSH: begin
        if (valid[flushSet][flushWay] && dirty[flushSet][flushWay]) begin
          bus.dWEN   = 1'b1;
          bus.daddr  = mkAddr(tags[flushSet][flushWay], flushSet, wordCnt);
          bus.dstore = data[flushWay][flushSet][wordCnt];
          if (!bus.dwait) begin
            if (lastWord) begin
              wordClr   = 1'b1;
              lineClean = 1'b1;
              lineAdv   = 1'b1;
            end else begin
              wordInc = 1'b1;
            end
          end
        end else begin
          lineAdv = 1'b1;
        end
        if (lineAdv && lastLine) nextState = HITWR;
      end
      HITWR: begin
        bus.dWEN   = 1'b1;
        bus.daddr  = {HITADDR[31:2], 2'b00};
        bus.dstore = hitCount;
        if (!bus.dwait) nextState = DONE;
      end
      DONE: bus.flushed = 1'b1;
      default: nextState = IDLE;
    endcase
    // Outputs stay quiet for the whole reset cycle, even mid-transfer.
    if (RST) begin
      bus.dhit     = 1'b0;
      bus.dmemload = '0;
      bus.flushed  = 1'b0;
      bus.dREN     = 1'b0;
      bus.dWEN     = 1'b0;
      bus.daddr    = '0;
      bus.dstore   = '0;
    end
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= nextState;
  end

  // Line metadata, counters and the latched miss request.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int s = 0; s < SETS; s++) begin
        valid[s] <= '0;
        dirty[s] <= '0;
      end
      lru      <= '0;
      wordCnt  <= '0;
      hitCount <= '0;
      flushSet <= '0;
      flushWay <= 1'b0;
      missTag  <= '0;
      missIdx  <= '0;
      victim   <= 1'b0;
    end else begin
      if (hitUpd) begin
        hitCount    <= hitCount + 32'd1;
        lru[reqIdx] <= ~hitWay;
        if (bus.dmemWEN) dirty[reqIdx][hitWay] <= 1'b1;
      end
      if (startMiss) begin
        missTag <= reqTag;
        missIdx <= reqIdx;
        victim  <= newVictim;
      end
      if (wordClr)      wordCnt <= '0;
      else if (wordInc) wordCnt <= wordCnt + 1'b1;
      if (install) begin
        valid[missIdx][victim] <= 1'b1;
        dirty[missIdx][victim] <= 1'b0;
        lru[missIdx]           <= ~victim;
      end
      if (lineClean) dirty[flushSet][flushWay] <= 1'b0;
      if (lineAdv) begin
        flushWay <= ~flushWay;
        if (flushWay) flushSet <= flushSet + 1'b1;
      end
    end
  end

  // Tag and data arrays; contents are not cleared by reset.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      if (hitUpd && bus.dmemWEN) data[hitWay][reqIdx][reqWord] <= bus.dmemstore;
      if (fillWe)  data[victim][missIdx][wordCnt] <= bus.dload;
      if (install) tags[missIdx][victim] <= missTag;
    end
  end
endmodule

// File: tb/tb_dcache_assoc.sv
// Randomised scoreboard bench for dcache_assoc against a flat-memory
// reference plus an MRU-ordered residency model per set.
module tb_dcache_assoc;
  localparam int unsigned SETS    = 8;
  localparam int unsigned WORDS   = 2;
  localparam logic [31:0] HITADDR = 32'h00003100;
  localparam int unsigned BLKSH   = 2 + $clog2(WORDS);

  logic CLK = 1'b0;
  logic RST = 1'b1;

  dcache_assoc_if bus ();

  dcache_assoc #(.SETS(SETS), .WORDS(WORDS), .HITADDR(HITADDR)) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  typedef struct { logic isWrite; logic [31:0] data; logic hit; int stamp; } expT;
  typedef struct { logic we; logic [31:0] addr; logic [31:0] data; } xferT;

  expT         expQ[$];
  xferT        xfers[$];
  logic [31:0] mem [logic [31:0]];
  logic [31:0] refMem [logic [31:0]];
  // Resident blocks per set; slot 0 is most recently used.
  logic [31:0] resBlk [SETS][2];
  logic        resDirty [SETS][2];
  int          resCnt [SETS];

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int reqCount    = 0;
  int waitMode    = 0;

  function automatic logic [31:0] initWord(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction

  function automatic logic [31:0] memRead(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : initWord(a);
  endfunction

  function automatic logic [31:0] refRead(input logic [31:0] a);
    return refMem.exists(a) ? refMem[a] : initWord(a);
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  task automatic finishRun();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  endtask

  task automatic checkQuiet(input string name);
    check({name, "_strobes"}, {28'b0, bus.dhit, bus.flushed, bus.dREN, bus.dWEN}, 32'd0);
    check({name, "_daddr"}, bus.daddr, 32'd0);
    check({name, "_dstore"}, bus.dstore, 32'd0);
    check({name, "_dmemload"}, bus.dmemload, 32'd0);
  endtask

  task automatic modelClear();
    for (int s = 0; s < SETS; s++) resCnt[s] = 0;
    reqCount = 0;
  endtask

  // Residency update: hit moves block to MRU; miss fills an empty slot or evicts the LRU.
  task automatic modelAccess(input logic wr, input logic [31:0] a, output logic hit);
    logic [31:0] blk;
    int s, pos;
    logic [31:0] tb;
    logic td;
    blk = a >> BLKSH;
    s   = int'(blk % SETS);
    pos = -1;
    for (int i = 0; i < resCnt[s]; i++) if (resBlk[s][i] == blk) pos = i;
    hit = (pos >= 0);
    if (pos < 0) begin
      if (resCnt[s] == 2) pos = 1;
      else begin
        pos = resCnt[s];
        resCnt[s]++;
      end
      resBlk[s][pos]   = blk;
      resDirty[s][pos] = 1'b0;
    end
    if (pos == 1) begin
      tb = resBlk[s][0]; td = resDirty[s][0];
      resBlk[s][0] = resBlk[s][1]; resDirty[s][0] = resDirty[s][1];
      resBlk[s][1] = tb; resDirty[s][1] = td;
    end
    if (wr) resDirty[s][0] = 1'b1;
  endtask

  // Issue one request at posedge+1 and hold it until the cache reports dhit.
  task automatic doReq(input logic wr, input logic [31:0] a, input logic [31:0] d, output int lat);
    logic hit;
    expT e;
    modelAccess(wr, a, hit);
    e.isWrite = wr;
    e.data    = refRead(a & ~32'h3);
    e.hit     = hit;
    e.stamp   = cyc;
    if (wr) refMem[a & ~32'h3] = d;
    reqCount++;
    bus.dmemREN   = wr ? 1'($urandom_range(0, 1)) : 1'b1;
    bus.dmemWEN   = wr;
    bus.dmemaddr  = a;
    bus.dmemstore = d;
    expQ.push_back(e);
    lat = 0;
    forever begin
      @(negedge CLK);
      if (bus.dhit) break;
      lat++;
      if (lat > 200) begin
        miscompares++;
        $display("FAIL request_timeout: addr %h got no dhit in 200 cycles, want dhit", a);
        finishRun();
      end
    end
    @(posedge CLK);
    #1;
    bus.dmemREN = 1'b0;
    bus.dmemWEN = 1'b0;
  endtask

  initial forever begin
    @(posedge CLK);
    cyc++;
  end

  // Scoreboard monitor: every dhit consumes the oldest expected response.
  initial begin : monitor
    expT e;
    forever begin
      @(negedge CLK);
      if (bus.dhit === 1'b1) begin
        if (expQ.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_dhit: got dhit=1 at addr %h, want dhit=0", bus.dmemaddr);
        end else begin
          e = expQ.pop_front();
          check("hit_without_miss", {31'b0, cyc == e.stamp}, {31'b0, e.hit});
          if (!e.isWrite) check("dmemload", bus.dmemload, e.data);
        end
      end
    end
  end

  // Memory responder: drives dwait/dload at negedge, logs transfers that complete.
  initial begin : responder
    int waitCnt;
    logic strobe, holding;
    logic [31:0] heldAddr;
    xferT x;
    waitCnt = 0; holding = 1'b0; heldAddr = '0;
    bus.dwait = 1'b0; bus.dload = '0;
    forever begin
      @(negedge CLK);
      strobe = bus.dREN | bus.dWEN;
      if (strobe) check("strobe_exclusive", {31'b0, bus.dREN & bus.dWEN}, 32'd0);
      if (holding && strobe) check("daddr_held", bus.daddr, heldAddr);
      bus.dwait = 1'b0;
      if (strobe) begin
        if (waitMode == 1) bus.dwait = 1'($urandom_range(0, 1));
        else if (waitMode == 2) begin
          if (waitCnt < 3) begin
            bus.dwait = 1'b1;
            waitCnt++;
          end else waitCnt = 0;
        end
      end
      bus.dload = memRead(bus.daddr);
      holding   = strobe & bus.dwait;
      heldAddr  = bus.daddr;
      if (strobe && !bus.dwait) begin
        x.we   = bus.dWEN;
        x.addr = bus.daddr;
        x.data = bus.dWEN ? bus.dstore : bus.dload;
        xfers.push_back(x);
        if (bus.dWEN) mem[bus.daddr] = bus.dstore;
      end
    end
  end

  initial begin : watchdog
    #600000;
    miscompares++;
    $display("FAIL watchdog: got no end of test by 60000 cycles, want completion");
    finishRun();
  end

  initial begin : stimulus
    int lat, dirtyLines, n, writes;
    logic wr;
    logic [31:0] a;
    logic [31:0] evAddr [4];
    logic [31:0] evData [2];
    logic        evWe [4];

    bus.dmemREN = 1'b0; bus.dmemWEN = 1'b0; bus.dmemaddr = '0;
    bus.dmemstore = '0; bus.halt = 1'b0;
    modelClear();

    repeat (3) @(posedge CLK);
    @(negedge CLK);
    checkQuiet("in_reset");
    @(posedge CLK); #1 RST = 1'b0;
    @(negedge CLK);
    checkQuiet("after_reset");
    @(posedge CLK); #1;

    // Cold read with no wait states: two fill reads, hit on the following cycle.
    mem[32'h40] = 32'hAAAA0000; refMem[32'h40] = 32'hAAAA0000;
    mem[32'h44] = 32'hBBBB0000; refMem[32'h44] = 32'hBBBB0000;
    xfers.delete();
    doReq(1'b0, 32'h40, '0, lat);
    check("cold_latency", lat, 32'd3);
    check("cold_xfer_count", xfers.size(), 32'd2);
    if (xfers.size() == 2) begin
      check("cold_xfer0", {xfers[0].we, xfers[0].addr[30:0]}, 32'h40);
      check("cold_xfer1", {xfers[1].we, xfers[1].addr[30:0]}, 32'h44);
    end

    // Dirty line in set 0 must be written back before the conflicting fill.
    doReq(1'b1, 32'h44, 32'h12345678, lat);
    doReq(1'b0, 32'h80, '0, lat);
    xfers.delete();
    doReq(1'b0, 32'hC0, '0, lat);
    evAddr = '{32'h40, 32'h44, 32'hC0, 32'hC4};
    evWe   = '{1'b1, 1'b1, 1'b0, 1'b0};
    evData = '{32'hAAAA0000, 32'h12345678};
    check("evict_xfer_count", xfers.size(), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < xfers.size()) begin
        check($sformatf("evict_xfer%0d_addr", i), xfers[i].addr, evAddr[i]);
        check($sformatf("evict_xfer%0d_we", i), {31'b0, xfers[i].we}, {31'b0, evWe[i]});
        if (i < 2) check($sformatf("evict_xfer%0d_data", i), xfers[i].data, evData[i]);
      end
    end

    // LRU: touching 0x80 makes 0xC0 the victim of 0x100.
    doReq(1'b0, 32'h80, '0, lat);
    doReq(1'b0, 32'h100, '0, lat);
    doReq(1'b0, 32'h80, '0, lat);

    // Three wait cycles per transfer: a two-word fill spans eight cycles.
    waitMode = 2;
    doReq(1'b0, 32'h208, '0, lat);
    check("slow_fill_latency", lat, 32'd9);

    // Reset in the middle of a fill.
    bus.dmemREN = 1'b1; bus.dmemaddr = 32'h300;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!bus.dREN && n < 20);
    check("fill_started", {31'b0, bus.dREN}, 32'd1);
    @(posedge CLK); #1;
    RST = 1'b1; bus.dmemREN = 1'b0;
    @(negedge CLK);
    checkQuiet("mid_fill_reset");
    @(posedge CLK); #1 RST = 1'b0;
    @(negedge CLK);
    checkQuiet("post_mid_fill_reset");
    @(posedge CLK); #1;
    modelClear();
    doReq(1'b0, 32'h80, '0, lat);

    // Random traffic over eight tags per set with random wait states.
    waitMode = 1;
    repeat (300) begin
      wr = ($urandom_range(0, 2) == 0);
      a  = (32'($urandom_range(0, 127)) << 2) | 32'($urandom_range(0, 3));
      doReq(wr, a, $urandom, lat);
    end

    // Flush: every dirty resident line, then the hit count.
    dirtyLines = 0;
    for (int s = 0; s < SETS; s++)
      for (int i = 0; i < resCnt[s]; i++) if (resDirty[s][i]) dirtyLines++;
    xfers.delete();
    bus.halt = 1'b1; bus.dmemREN = 1'b1; bus.dmemaddr = 32'h80;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!bus.flushed && n < 3000);
    check("flushed_set", {31'b0, bus.flushed}, 32'd1);
    check("flush_xfer_count", xfers.size(), 32'(dirtyLines * WORDS + 1));
    writes = 0;
    foreach (xfers[i]) if (xfers[i].we) writes++;
    check("flush_all_writes", writes, xfers.size());
    if (xfers.size() > 0) begin
      check("hitcount_addr", xfers[xfers.size()-1].addr, HITADDR);
      check("hitcount_value", xfers[xfers.size()-1].data, reqCount);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge CLK); #1;
      bus.halt = 1'($urandom_range(0, 1));
      bus.dmemWEN = 1'($urandom_range(0, 1));
      @(negedge CLK);
      check("flushed_sticky", {31'b0, bus.flushed}, 32'd1);
    end
    foreach (refMem[k]) check($sformatf("mem_%h", k), memRead(k), refMem[k]);
    finishRun();
  end
endmodule
